// File: rtl/sram_image_loader.sv
// rtl/sram_image_loader.sv - streams header/row beats into the input SRAM image layout
module sram_image_loader (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        ldr_start,
    output logic        ldr_busy,
    output logic        ldr_done,
    output logic        ldr_error,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_eos,
    output logic [11:0] dut_sram_write_address,
    output logic [15:0] dut_sram_write_data,
    output logic        dut_sram_write_enable
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_HDR    = 2'd1;
    localparam logic [1:0]  ST_ROW    = 2'd2;
    localparam logic [1:0]  ST_FIN    = 2'd3;
    localparam logic [15:0] SENTINEL  = 16'h00FF;
    localparam logic [11:0] LAST_ADDR = 12'hFFF;

    logic [1:0]  state, state_nxt;
    logic [4:0]  row_cnt, row_nxt;
    logic [4:0]  dim, dim_nxt;
    logic [11:0] ptr, ptr_nxt;
    logic        we_nxt;
    logic [11:0] wa_nxt;
    logic [15:0] wd_nxt;
    logic        err_set;
    logic        done_nxt;
    logic        beat;
    logic        hdr_ok;
    logic        at_last;
    logic [15:0] row_mask;

    assign beat    = in_valid & in_ready;
    assign at_last = (ptr == LAST_ADDR);

    // Only the three supported image dimensions are legal headers
    always_comb begin
        hdr_ok = (in_data == 16'd10) || (in_data == 16'd12) || (in_data == 16'd16);
    end

    // Keep columns 0..N-1 of a row; N=16 passes the whole word
    always_comb begin
        if (dim == 5'd16) begin
            row_mask = 16'hFFFF;
        end else begin
            row_mask = (16'd1 << dim) - 16'd1;
        end
    end

    // Next-state, pointer and write scheduling; address 4095 is kept for the sentinel
    always_comb begin
        state_nxt = state;
        row_nxt   = row_cnt;
        dim_nxt   = dim;
        ptr_nxt   = ptr;
        we_nxt    = 1'b0;
        wa_nxt    = dut_sram_write_address;
        wd_nxt    = dut_sram_write_data;
        err_set   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ldr_start) begin
                    state_nxt = ST_HDR;
                    ptr_nxt   = 12'd0;
                end
            end
            ST_HDR: begin
                if (beat) begin
                    if (in_eos) begin
                        state_nxt = ST_FIN;
                        we_nxt    = 1'b1;
                        wa_nxt    = ptr;
                        wd_nxt    = SENTINEL;
                        ptr_nxt   = at_last ? ptr : ptr + 12'd1;
                    end else if (!hdr_ok || at_last) begin
                        state_nxt = ST_IDLE;
                        err_set   = 1'b1;
                    end else begin
                        state_nxt = ST_ROW;
                        row_nxt   = in_data[4:0];
                        dim_nxt   = in_data[4:0];
                        we_nxt    = 1'b1;
                        wa_nxt    = ptr;
                        wd_nxt    = in_data;
                        ptr_nxt   = ptr + 12'd1;
                    end
                end
            end
            ST_ROW: begin
                if (beat) begin
                    if (in_eos || at_last) begin
                        state_nxt = ST_IDLE;
                        err_set   = 1'b1;
                    end else begin
                        we_nxt    = 1'b1;
                        wa_nxt    = ptr;
                        wd_nxt    = in_data & row_mask;
                        ptr_nxt   = ptr + 12'd1;
                        row_nxt   = row_cnt - 5'd1;
                        if (row_cnt == 5'd1) begin
                            state_nxt = ST_HDR;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state                  <= ST_IDLE;
            row_cnt                <= 5'd0;
            dim                    <= 5'd0;
            ptr                    <= 12'd0;
            ldr_busy               <= 1'b0;
            ldr_done               <= 1'b0;
            ldr_error              <= 1'b0;
            in_ready               <= 1'b0;
            dut_sram_write_enable  <= 1'b0;
            dut_sram_write_address <= 12'd0;
            dut_sram_write_data    <= 16'd0;
        end else begin
            state                  <= state_nxt;
            row_cnt                <= row_nxt;
            dim                    <= dim_nxt;
            ptr                    <= ptr_nxt;
            ldr_busy               <= (state_nxt != ST_IDLE);
            ldr_done               <= done_nxt;
            in_ready               <= (state_nxt == ST_HDR) || (state_nxt == ST_ROW);
            dut_sram_write_enable  <= we_nxt;
            dut_sram_write_address <= wa_nxt;
            dut_sram_write_data    <= wd_nxt;
            if (state == ST_IDLE && ldr_start) begin
                ldr_error <= 1'b0;
            end else if (err_set) begin
                ldr_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_image_loader.sv
// tb/tb_sram_image_loader.sv - scoreboard bench for sram_image_loader
module tb_sram_image_loader;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        ldr_start = 1'b0;
    logic        ldr_busy;
    logic        ldr_done;
    logic        ldr_error;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic        in_eos = 1'b0;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
        logic        sent;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    int   mptr = 0;
    logic prev_sent = 1'b0;

    sram_image_loader dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .ldr_start              (ldr_start),
        .ldr_busy               (ldr_busy),
        .ldr_done               (ldr_done),
        .ldr_error              (ldr_error),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_data                (in_data),
        .in_eos                 (in_eos),
        .dut_sram_write_address (wr_addr),
        .dut_sram_write_data    (wr_data),
        .dut_sram_write_enable  (wr_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop one expected write per observed write, and check done timing
    always @(negedge clk) begin
        exp_t e;
        if (ldr_done) begin
            done_count++;
            check("done_after_sentinel", {31'd0, prev_sent}, 32'd1);
        end else if (prev_sent) begin
            check("done_pulse", {31'd0, ldr_done}, 32'd1);
        end
        prev_sent = 1'b0;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {20'd0, wr_addr}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", {20'd0, wr_addr}, {20'd0, e.addr});
                check("write_data", {16'd0, wr_data}, {16'd0, e.data});
                prev_sent = e.sent;
            end
        end
    end

    function automatic logic [15:0] fmt_row(input logic [15:0] d, input int n);
        logic [15:0] keep;
        keep = 16'hFFFF >> (16 - n);
        return d & keep;
    endfunction

    task automatic push(input int addr, input logic [15:0] data, input logic s);
        exp_t e;
        e.addr = addr[11:0];
        e.data = data;
        e.sent = s;
        exp_q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        ldr_start = 1'b1;
        @(negedge clk);
        ldr_start = 1'b0;
        mptr = 0;
    endtask

    task automatic beat(input logic [15:0] d, input logic eos, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_eos   = eos;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_eos   = 1'b0;
    endtask

    task automatic hdr(input int n, input int gap);
        push(mptr, n[15:0], 1'b0);
        mptr++;
        beat(n[15:0], 1'b0, gap);
    endtask

    task automatic row(input logic [15:0] d, input int n, input int gap);
        push(mptr, fmt_row(d, n), 1'b0);
        mptr++;
        beat(d, 1'b0, gap);
    endtask

    task automatic image(input int n, input logic [15:0] seed, input int gap);
        hdr(n, gap);
        for (int r = 0; r < n; r++) begin
            row(seed ^ (16'h1357 * r[15:0]), n, (gap + r) % 3 * (gap != 0 ? 1 : 0));
        end
    endtask

    task automatic send_eos(input int gap);
        push(mptr, 16'h00FF, 1'b1);
        mptr++;
        beat(16'h1234, 1'b1, gap);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dc;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, ldr_busy}, 32'd0);
        check("rst_done", {31'd0, ldr_done}, 32'd0);
        check("rst_error", {31'd0, ldr_error}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, wr_en}, 32'd0);
        check("rst_addr", {20'd0, wr_addr}, 32'd0);
        check("rst_data", {16'd0, wr_data}, 32'd0);
        reset_b = 1'b1;
        repeat (2) @(negedge clk);

        // Single image N=10, rows all ones
        do_start();
        check("busy_after_start", {31'd0, ldr_busy}, 32'd1);
        check("ready_in_hdr", {31'd0, in_ready}, 32'd1);
        dc = done_count;
        push(0, 16'h000A, 1'b0);
        beat(16'd10, 1'b0, 0);
        for (int r = 1; r <= 10; r++) begin
            push(r, 16'h03FF, 1'b0);
            beat(16'hFFFF, 1'b0, 0);
        end
        push(11, 16'h00FF, 1'b1);
        beat(16'h0000, 1'b1, 0);
        drain();
        check("single_done_count", done_count - dc, 32'd1);
        check("single_busy_low", {31'd0, ldr_busy}, 32'd0);
        check("single_error", {31'd0, ldr_error}, 32'd0);
        check("single_ready_low", {31'd0, in_ready}, 32'd0);
        check("single_addr_hold", {20'd0, wr_addr}, 32'd11);

        // Three images with gaps: headers at 0, 17, 30; sentinel at 41
        do_start();
        dc = done_count;
        image(16, 16'hBEEF, 2);
        check("img2_ptr", mptr, 32'd17);
        image(12, 16'hC3A5, 1);
        check("img3_ptr", mptr, 32'd30);
        image(10, 16'h5AF0, 3);
        send_eos(2);
        drain();
        check("multi_done_count", done_count - dc, 32'd1);
        check("multi_busy_low", {31'd0, ldr_busy}, 32'd0);

        // Bad header
        do_start();
        dc = done_count;
        beat(16'd11, 1'b0, 0);
        check("badhdr_error", {31'd0, ldr_error}, 32'd1);
        check("badhdr_busy", {31'd0, ldr_busy}, 32'd0);
        check("badhdr_ready", {31'd0, in_ready}, 32'd0);
        drain();
        check("badhdr_no_done", done_count - dc, 32'd0);
        do_start();
        check("restart_clears_error", {31'd0, ldr_error}, 32'd0);
        send_eos(0);
        drain();

        // Early eos after 5 of 12 rows
        do_start();
        dc = done_count;
        hdr(12, 0);
        for (int r = 0; r < 5; r++) begin
            row(16'hF0F0 + r[15:0], 12, 1);
        end
        beat(16'h0000, 1'b1, 0);
        check("early_error", {31'd0, ldr_error}, 32'd1);
        check("early_busy", {31'd0, ldr_busy}, 32'd0);
        drain();
        check("early_no_done", done_count - dc, 32'd0);
        check("early_last_addr", {20'd0, wr_addr}, 32'd5);

        // Address full: 240 images of N=16, then a header at 4080
        do_start();
        for (int i = 0; i < 240; i++) begin
            image(16, i[15:0] * 16'h0101, 0);
        end
        hdr(16, 0);
        for (int r = 0; r < 14; r++) begin
            row(16'hA000 + r[15:0], 16, 0);
        end
        beat(16'h7777, 1'b0, 0);
        check("full_error", {31'd0, ldr_error}, 32'd1);
        check("full_busy", {31'd0, ldr_busy}, 32'd0);
        drain();
        check("full_last_addr", {20'd0, wr_addr}, 32'd4094);

        // Mid-session reset during ROW
        do_start();
        hdr(10, 0);
        for (int r = 0; r < 3; r++) begin
            row(16'h0F0F, 10, 0);
        end
        drain();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0123;
        @(posedge clk);
        #1;
        check("pre_reset_we", {31'd0, wr_en}, 32'd1);
        reset_b = 1'b0;
        #1;
        check("arst_we", {31'd0, wr_en}, 32'd0);
        check("arst_addr", {20'd0, wr_addr}, 32'd0);
        check("arst_data", {16'd0, wr_data}, 32'd0);
        check("arst_busy", {31'd0, ldr_busy}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {31'd0, ldr_busy}, 32'd0);
        do_start();
        dc = done_count;
        image(12, 16'h9C9C, 1);
        send_eos(0);
        drain();
        check("fresh_done_count", done_count - dc, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_image_loader.md
SRAM_IMAGE_LOADER -- requirements
Module: sram_image_loader

Interface
REQ-001 SHALL have the port: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have the port: reset_b  input  1  asynchronous, active-low reset.
REQ-003 SHALL have the port: ldr_start  input  1  one-cycle pulse; begins a load session at address 0.
REQ-004 SHALL have the port: ldr_busy  output  1  high from the cycle after an accepted start until done or error.
REQ-005 SHALL have the port: ldr_done  output  1  one-cycle pulse after the sentinel write.
REQ-006 SHALL have the port: ldr_error  output  1  sticky error flag, cleared by the next accepted ldr_start.
REQ-007 SHALL have the port: in_valid  input  1  host beat valid.
REQ-008 SHALL have the port: in_ready  output  1  loader accepts the beat when in_valid and in_ready are both high.
REQ-009 SHALL have the port: in_data  input  16  header word (image dimension) or one image row, LSB = column 0.
REQ-010 SHALL have the port: in_eos  input  1  end-of-stream, qualified by in_valid; in_data is ignored on that beat.
REQ-011 SHALL have the port: dut_sram_write_address  output  12  input-SRAM write address.
REQ-012 SHALL have the port: dut_sram_write_data  output  16  input-SRAM write data.
REQ-013 SHALL have the port: dut_sram_write_enable  output  1  write strobe, one word per cycle.
REQ-014 Clocking and reset SHALL be fixed as one clock (clk) with asynchronous, active-low reset (reset_b).

Function
REQ-015 The block SHALL write images into the input SRAM in the layout the convolution engine reads:
  - per image, one header word holding N (10, 12 or 16);
  - then N row words;
  - images back to back from address 0;
  - after the last image, the sentinel 16'h00FF.
REQ-016 States SHALL be IDLE, HDR, ROW and FIN, as listed below.
  - IDLE: in_ready=0. An accepted ldr_start moves to HDR, clears the address pointer to 0, and clears ldr_error.
  - HDR: in_ready=1. A beat with in_eos=1 moves to FIN. A beat with valid N moves to ROW and loads row_cnt=N. A beat with invalid N moves to IDLE and sets ldr_error.
  - ROW: in_ready=1. Each beat decrements row_cnt. The beat that takes row_cnt from 1 to 0 returns to HDR. A beat with in_eos=1 in ROW moves to IDLE, sets ldr_error, and writes nothing.
  - FIN: in_ready=0 for one cycle. Emits the sentinel write. Pulses ldr_done. Returns to IDLE.
REQ-017 A header beat SHALL be valid only if in_data equals 16'd10, 16'd12 or 16'd16 exactly; the stored header word is in_data unchanged.
REQ-018 Row words SHALL be written with bits [15:N] forced to 0; for N=16 there is no masking.
REQ-019 Every accepted non-error beat SHALL produce exactly one write on the following cycle: enable=1, address = pointer, data = formatted word; the pointer increments after each write.
REQ-020 Write outputs SHALL be registered, with write latency exactly 1 cycle from acceptance.
REQ-021 dut_sram_write_enable SHALL be 0 in every cycle without a scheduled write.
REQ-022 Address and data SHALL hold their last values while enable is 0.
REQ-023 A non-sentinel beat whose write address would be 4095 SHALL NOT be written; the block goes to IDLE with ldr_error=1. This reserves room for the sentinel, so the pointer never wraps.
REQ-024 ldr_start while ldr_busy=1 SHALL be ignored.
REQ-025 On error, ldr_busy SHALL drop on the cycle after the offending beat, and ldr_done SHALL NOT pulse.
REQ-026 in_ready SHALL be a registered function of state, so it has no combinational path from in_valid.
REQ-027 The host MAY hold in_valid low for any number of cycles; the state and row_cnt SHALL hold.

Reset
REQ-028 While reset_b=0, the following SHALL hold:
  - state=IDLE;
  - ldr_busy, ldr_done, ldr_error, in_ready = 0;
  - dut_sram_write_enable=0;
  - dut_sram_write_address=0, dut_sram_write_data=0;
  - row_cnt=0.
REQ-029 Reset asserted mid-session SHALL abort immediately with no further writes; after release the block waits in IDLE for ldr_start.

Verification
REQ-030 Single image. Start, then header 16'd10, then 10 rows of 16'hFFFF, then eos. Required:
  - writes addr0=000A, addr1..10=03FF, addr11=00FF;
  - ldr_done one cycle after the addr11 write;
  - ldr_busy low afterwards.
REQ-031 Three images (16, 12, 10) with in_valid gaps between beats. Required:
  - headers at addresses 0, 17, 30;
  - sentinel at address 41;
  - no writes in idle gaps.
REQ-032 Bad header: header 16'd11. Required: no write, ldr_error=1, ldr_busy=0, in_ready=0. A new start clears ldr_error.
REQ-033 Early eos: eos after 5 of 12 rows. Required: 6 writes total, no sentinel, ldr_error=1, no ldr_done.
REQ-034 Address full: 240 images of N=16 (4080 words), then a header. Required:
  - header written at 4080;
  - the 15th row, which would land at 4095, is rejected with ldr_error=1.
REQ-035 Mid-session reset: reset_b pulsed low during ROW. Required: all outputs 0 asynchronously, then a fresh session writes from address 0.
